// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: EX operand forwarding plus load-use / memory-wait stall FSM.
// Define HAZARD_PERF_CNT_EN to add the Stall_Cycles performance counter output.
module hazard_forward_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int LOAD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] D_Rs1,
  input  logic [ADDR_WIDTH-1:0] D_Rs2,
  input  logic [ADDR_WIDTH-1:0] E_Rs1,
  input  logic [ADDR_WIDTH-1:0] E_Rs2,
  input  logic [ADDR_WIDTH-1:0] E_Rd,
  input  logic                  E_RegWrite,
  input  logic                  E_MemRead,
  input  logic [ADDR_WIDTH-1:0] M_Rd,
  input  logic [ADDR_WIDTH-1:0] W_Rd,
  input  logic                  M_RegWrite,
  input  logic                  W_RegWrite,
  input  logic                  Mem_Busy,
  output logic [1:0]            AForward,
  output logic [1:0]            BForward,
  output logic                  PC_Stall,
  output logic                  D_Stall,
  output logic                  E_Flush,
  output logic                  Freeze
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           Stall_Cycles
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD_STALL, MEM_WAIT} state_t;

  state_t     state_reg, state_next, eff_state;
  logic [2:0] cnt_reg, cnt_next;
  logic       load_use;
  logic       unused_e_regwrite;

  logic [ADDR_WIDTH-1:0] e_rs [2];
  logic [1:0]            fwd  [2];

  assign unused_e_regwrite = E_RegWrite;
  assign e_rs[0] = E_Rs1;
  assign e_rs[1] = E_Rs2;

  // Memory stage has the newer value, so it is checked before writeback.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd[gi] = 2'b00;
        if (M_RegWrite && (M_Rd != '0) && (M_Rd == e_rs[gi]))
          fwd[gi] = 2'b10;
        else if (W_RegWrite && (W_Rd != '0) && (W_Rd == e_rs[gi]))
          fwd[gi] = 2'b01;
      end
    end
  endgenerate

  assign AForward = fwd[0];
  assign BForward = fwd[1];

  assign load_use = E_MemRead && (E_Rd != '0) && ((E_Rd == D_Rs1) || (E_Rd == D_Rs2));

  // Leaving MEM_WAIT, the cycle behaves like the state being resumed so no
  // bubble is inserted; a nonzero counter marks an interrupted load stall.
  always_comb begin
    eff_state = state_reg;
    if (!rst_n)
      eff_state = IDLE;
    else if (state_reg == MEM_WAIT && !Mem_Busy)
      eff_state = (cnt_reg != 3'd0) ? LOAD_STALL : IDLE;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    PC_Stall   = 1'b0;
    D_Stall    = 1'b0;
    E_Flush    = 1'b0;
    Freeze     = 1'b0;
    if (Mem_Busy) begin
      Freeze     = 1'b1;
      PC_Stall   = 1'b1;
      D_Stall    = 1'b1;
      state_next = MEM_WAIT;
    end else begin
      case (eff_state)
        IDLE: begin
          state_next = IDLE;
          cnt_next   = 3'd0;
          if (load_use) begin
            PC_Stall = 1'b1;
            D_Stall  = 1'b1;
            E_Flush  = 1'b1;
            if (LOAD_LAT > 1) begin
              state_next = LOAD_STALL;
              cnt_next   = 3'(LOAD_LAT - 1);
            end
          end
        end
        LOAD_STALL: begin
          PC_Stall = 1'b1;
          D_Stall  = 1'b1;
          E_Flush  = 1'b1;
          if (cnt_reg <= 3'd1) begin
            state_next = IDLE;
            cnt_next   = 3'd0;
          end else begin
            state_next = LOAD_STALL;
            cnt_next   = cnt_reg - 3'd1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt_reg <= 32'd0;
    else if (PC_Stall)
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign Stall_Cycles = stall_cnt_reg;
`endif

endmodule
